// File: rtl/mux_lut_gate.sv
// Two-input LUT gate built from a 2:1 mux tree per bit, with elementwise and reduce (fold) modes.
// Optional MUX_LUT_GATE_COUNT_EN adds a 16-bit output-handshake counter port out_count.
module mux_lut_gate #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_tt,
  input  logic             in_mode,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef MUX_LUT_GATE_COUNT_EN
  output logic [15:0]      out_count,
`endif
  output logic [WIDTH-1:0] out_data
);

  // state | meaning
  // IDLE  | no packet open
  // ACC   | reduce packet open, r_acc holds the partial fold
  typedef enum logic {S_IDLE, S_ACC} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [3:0]       r_tt;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;

  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_lo;
  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_f;
  logic [3:0]       w_tt;
  logic             w_accept;
  logic             w_consume;
  logic             w_write;
  logic             w_in_acc;

  assign w_in_acc  = (r_state == S_ACC);
  assign in_ready  = !r_out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_consume = r_out_valid && out_ready;

  // Inside a packet the accumulator takes the A side and the latched table applies.
  assign w_op_a = w_in_acc ? r_acc : in_a;
  assign w_tt   = w_in_acc ? r_tt  : in_tt;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign w_lo[gi] = in_b[gi]   ? w_tt[1]  : w_tt[0];
      assign w_hi[gi] = in_b[gi]   ? w_tt[3]  : w_tt[2];
      assign w_f[gi]  = w_op_a[gi] ? w_hi[gi] : w_lo[gi];
    end
  endgenerate

  assign w_write = w_accept && (w_in_acc ? in_last : (!in_mode || in_last));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_tt        <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_write) begin
        r_out_data  <= w_f;
        r_out_valid <= 1'b1;
      end else if (w_consume) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_accept && in_mode && !in_last) begin
            r_acc   <= w_f;
            r_tt    <= in_tt;
            r_state <= S_ACC;
          end
        end
        S_ACC: begin
          if (w_accept) begin
            if (in_last) r_state <= S_IDLE;
            else         r_acc   <= w_f;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef MUX_LUT_GATE_COUNT_EN
  logic [15:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_count <= '0;
    else if (w_consume) r_count <= r_count + 16'd1;
  end

  assign out_count = r_count;
`endif

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_mux_lut_gate.sv
// Directed bench for mux_lut_gate: elementwise, reduce, backpressure, reset and exhaustive LUT vectors.
// Define MUX_LUT_GATE_COUNT_EN to also exercise out_count wrap.
module tb_mux_lut_gate;
  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [3:0]       in_tt;
  logic             in_mode;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
`ifdef MUX_LUT_GATE_COUNT_EN
  logic [15:0]      out_count;
`endif

  int n_cmp;
  int n_fail;

  mux_lut_gate #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tt     (in_tt),
    .in_mode   (in_mode),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef MUX_LUT_GATE_COUNT_EN
    .out_count (out_count),
`endif
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic [3:0] tt,
                      input logic mode, input logic last);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_tt    = tt;
    in_mode  = mode;
    in_last  = last;
  endtask

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_tt     = '0;
    in_mode   = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    step();
    rst_n = 1'b1;
    step();

    // Elementwise OR
    beat(8'hA0, 8'h05, 4'b1110, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    check("or_valid", 64'(out_valid), 64'd1);
    check("or_data",  64'(out_data),  64'hA5);
    step();
    check("or_consumed", 64'(out_valid), 64'd0);

    // AND reduce; in_a and in_tt on later beats must be ignored
    beat(8'hFF, 8'hF0, 4'b1000, 1'b1, 1'b0);
    step();
    check("and_b1_novalid", 64'(out_valid), 64'd0);
    beat(8'h00, 8'h3C, 4'b1110, 1'b1, 1'b0);
    step();
    check("and_b2_novalid", 64'(out_valid), 64'd0);
    beat(8'h00, 8'h0F, 4'b0110, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    check("and_valid", 64'(out_valid), 64'd1);
    check("and_data",  64'(out_data),  64'h00);
    step();
    check("and_consumed", 64'(out_valid), 64'd0);

    // Backpressure: XOR result held for 10 cycles
    out_ready = 1'b0;
    beat(8'h0F, 8'hFF, 4'b0110, 1'b0, 1'b0);
    step();
    beat(8'h00, 8'h00, 4'b0110, 1'b0, 1'b0);
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_hold_data",  64'(out_data),  64'hF0);
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_hold_ready", 64'(in_ready),  64'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_comb", 64'(in_ready), 64'd1);
    step();
    check("b2b_0_valid", 64'(out_valid), 64'd1);
    check("b2b_0_data",  64'(out_data),  64'h00);
    beat(8'hAA, 8'h55, 4'b0110, 1'b0, 1'b0);
    step();
    check("b2b_1_data",  64'(out_data),  64'hFF);
    beat(8'h12, 8'h34, 4'b0110, 1'b0, 1'b0);
    step();
    check("b2b_2_data",  64'(out_data),  64'h26);
    check("b2b_2_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    step();
    check("b2b_drained", 64'(out_valid), 64'd0);

    // Async reset while a result is held
    out_ready = 1'b0;
    beat(8'h81, 8'h00, 4'b1110, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    check("held_before_rst", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_held_valid", 64'(out_valid), 64'd0);
    check("rst_held_data",  64'(out_data),  64'd0);
    check("rst_held_ready", 64'(in_ready),  64'd1);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();

    // Reset mid XOR packet, then a fresh single-beat packet
    beat(8'hFF, 8'h0F, 4'b0110, 1'b1, 1'b0);
    step();
    beat(8'h00, 8'h33, 4'b0110, 1'b1, 1'b0);
    step();
    in_valid = 1'b0;
    check("xor_mid_novalid", 64'(out_valid), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 64'(out_valid), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    beat(8'h12, 8'h34, 4'b0110, 1'b1, 1'b1);
    step();
    in_valid = 1'b0;
    check("post_rst_valid", 64'(out_valid), 64'd1);
    check("post_rst_data",  64'(out_data),  64'h26);
    step();

    // Exhaustive truth tables: bits 0..3 carry (a,b) = 00,01,10,11
    for (int t = 0; t < 16; t++) begin
      logic [3:0] tt;
      tt = 4'(t);
      beat(8'b0000_1100, 8'b0000_1010, tt, 1'b0, 1'b0);
      step();
      check("lut_exhaustive", 64'(out_data), 64'({{4{tt[0]}}, tt}));
    end
    in_valid = 1'b0;
    step();

`ifdef MUX_LUT_GATE_COUNT_EN
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check("count_rst", 64'(out_count), 64'd0);
    beat(8'h01, 8'h02, 4'b1110, 1'b0, 1'b0);
    for (int i = 0; i < 65537; i++) step();
    in_valid = 1'b0;
    step();
    check("count_wrap", 64'(out_count), 64'd1);
    check("count_drained", 64'(out_valid), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
